usb_phy_tx: RTL and testbench
=============================

# usb_phy_tx

Transmit half of the USB PHY. It consumes the UTMI transmit byte stream produced by the SIE (`utmi_data`, `utmi_txvalid`, `utmi_txready`) and drives the USB D+/D- lines. It generates SYNC, serialises bytes LSB-first with bit stuffing and NRZI encoding, and appends EOP. It supports full speed (12 Mb/s) and low speed (1.5 Mb/s) from a single 48 MHz clock.

## Interface
Parameters:
- `CLK_DIV_FS`, default 4: clocks per full-speed bit.
- `CLK_DIV_LS`, default 32: clocks per low-speed bit.

Ports:
- `clk_i`  in  1  system clock (48 MHz). Reset is asynchronous and active-high.
- `rst_i`  in  1  asynchronous active-high reset.
- `utmi_data_i`  in  8  byte to transmit; held stable by the SIE until `utmi_txready_o`.
- `utmi_txvalid_i`  in  1  packet in progress; deassertion ends the packet.
- `utmi_txready_o`  out  1  one-cycle pulse: the byte on `utmi_data_i` is latched this cycle.
- `utmi_xcvrselect_i`  in  2  `2'b10` selects low speed; any other value selects full speed.
- `usb_dp_o`  out  1  D+ drive value.
- `usb_dn_o`  out  1  D- drive value.
- `usb_oe_o`  out  1  line driver enable.
- `busy_o`  out  1  high in every state except IDLE.

## Operation
- Line encoding:
  - Full speed: J = (dp=1, dn=0), K = (0, 1).
  - Low speed: J = (0, 1), K = (1, 0).
  - SE0 = (0, 0) at either speed.
- Speed select: `utmi_xcvrselect_i` is sampled only in IDLE when a packet starts. The latched mode (polarity and divider) holds until the block returns to IDLE.
- Bit strobe `bit_ce`:
  - Driven by a divide counter that is cleared on leaving IDLE.
  - Fires on the last clock of each bit period: every `CLK_DIV_FS` or `CLK_DIV_LS` clocks.
  - The line outputs change only on the clock after `bit_ce`, or on IDLE exit.
- States:
  - IDLE: `usb_oe_o`=0, line=J. When `utmi_txvalid_i`=1, go to SYNC on the next clock.
  - SYNC: drives the 8 raw bits 0,0,0,0,0,0,0,1 through NRZI, giving KJKJKJKK. On the `bit_ce` of the 8th bit:
    - if `utmi_txvalid_i`=1: latch `utmi_data_i` into the shift register, pulse `utmi_txready_o`, go to DATA;
    - else: go to EOP_SE0.
  - DATA: shifts 8 bits LSB-first, inserting stuff bits as needed. On the `bit_ce` that completes the 8th data bit (and any stuff bit that bit requires):
    - if `utmi_txvalid_i`=1: latch the next byte and pulse `utmi_txready_o`;
    - else: go to EOP_SE0.
  - EOP_SE0: SE0 for 2 bit times, then go to EOP_J.
  - EOP_J: J for 1 bit time, then go to IDLE with `usb_oe_o`=0.
- NRZI: a raw 0 toggles J/K; a raw 1 holds the current level. The encoder starts at J on IDLE exit.
- Bit stuffing:
  - A 3-bit counter of consecutive raw 1s includes the SYNC bits, so it holds 1 after SYNC.
  - When the count reaches 6, a raw 0 is inserted before the next bit and the counter clears. A raw 0 data bit also clears it.
  - The check also applies after the last data bit: a pending stuff bit is sent before EOP.
- Defaults:
  - `utmi_data_i` is ignored outside latch cycles.
  - `utmi_txready_o` is never high in IDLE, EOP_SE0 or EOP_J.
  - `busy_o` = (state != IDLE).

## Timing
- Reset values:
  - state IDLE, `utmi_txready_o`=0, `usb_oe_o`=0, line=J for full speed (`usb_dp_o`=1, `usb_dn_o`=0), `busy_o`=0.
  - Divider, stuff counter and shift register all 0.
  - Reset asserted mid-packet drops `usb_oe_o` asynchronously and abandons the packet; no EOP is sent.
- Start latency: `utmi_txvalid_i` seen high at clock t gives `usb_oe_o`=1 and the first K at t+1.
- First `utmi_txready_o`: 8 bit times after SYNC start, i.e. 32 clocks at full speed and 256 at low speed.
- Byte spacing: consecutive `utmi_txready_o` pulses are 8×DIV clocks apart, plus DIV clocks for each stuff bit in the byte.
- Packet end: `utmi_txvalid_i` dropping mid-byte has no effect until the byte boundary; the byte in flight always completes.
- Simultaneous events: `utmi_txvalid_i` rising in the same cycle as EOP_J completes is not accepted until the block is back in IDLE. The next SYNC starts 1 clock after IDLE is entered.
- Low-speed SOF keep-alive: the SIE drops `utmi_txvalid_i` after 1 byte, and this block sends SYNC + PID + EOP unchanged.

## Test plan
- Full-speed single byte 0xD2 (ACK), txvalid dropped after the first txready:
  - required line sequence: K J K J K J K K, J J K J J K K K, SE0 SE0 J, then oe=0;
  - every bit lasts 4 clocks.
- Full-speed bytes 0xFF, 0x00 back-to-back:
  - a stuff bit follows the 5th data bit of 0xFF;
  - the txready-to-txready interval is 36 clocks, and the next interval is 32 clocks.
- Low speed (`xcvrselect`=2'b10), byte 0xD2:
  - same J/K pattern with inverted dp/dn polarity, 32 clocks per bit;
  - first txready arrives 256 clocks after txvalid.
- Three-byte OUT-style stream (0xE1, 0x15, 0x10):
  - exactly 3 txready pulses, each latching the byte presented at that time;
  - EOP starts at the first byte boundary after txvalid falls.
- `xcvrselect` changed mid-packet:
  - no effect on polarity or rate until the next packet.
- `rst_i` asserted during DATA:
  - oe=0 immediately, busy_o=0;
  - after release, a new packet starts cleanly with SYNC.

Source files
------------

// File: rtl/usb_phy_tx.sv
`timescale 1ns/1ps
// Purpose: USB PHY transmitter. It takes the UTMI byte stream, sends SYNC, serialises
//   bytes LSB-first with bit stuffing and NRZI, and ends each packet with SE0,SE0,J.
// Latency: txvalid seen at clock t gives oe=1 and the first SYNC K at t+1.
//   The first txready comes 8 bit times later. Bytes then follow every 8 bit times,
//   plus one bit time for each stuff bit.
// Backpressure: the SIE holds utmi_data_i until the one-cycle utmi_txready_o pulse.
//   Dropping txvalid takes effect only at the next byte boundary.
// Ports:
//   clk_i, rst_i                 48 MHz clock, asynchronous active-high reset
//   utmi_data_i/txvalid_i        byte to send / packet in progress
//   utmi_txready_o               byte on utmi_data_i is consumed this cycle
//   utmi_xcvrselect_i            2'b10 = low speed, anything else = full speed
//   usb_dp_o, usb_dn_o, usb_oe_o line drive values and driver enable
//   busy_o                       high whenever not IDLE
module usb_phy_tx #(
  parameter int CLK_DIV_FS = 4,
  parameter int CLK_DIV_LS = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] utmi_data_i,
  input  logic       utmi_txvalid_i,
  output logic       utmi_txready_o,
  input  logic [1:0] utmi_xcvrselect_i,
  output logic       usb_dp_o,
  output logic       usb_dn_o,
  output logic       usb_oe_o,
  output logic       busy_o
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_EOP_SE0 = 3'd3;
  localparam logic [2:0] ST_EOP_J   = 3'd4;

  localparam logic [7:0] DIV_MAX_FS = 8'(CLK_DIV_FS - 1);
  localparam logic [7:0] DIV_MAX_LS = 8'(CLK_DIV_LS - 1);

  logic [2:0] r_state;
  logic [7:0] r_div;
  logic       r_ls;      // speed latched at packet start
  logic       r_oe;
  logic       r_level;   // NRZI level: 1 = J, 0 = K
  logic       r_se0;
  logic [2:0] r_cnt;     // SYNC bit index, or EOP SE0 bit index
  logic [3:0] r_bitcnt;  // data bits of the current byte already put on the line
  logic [2:0] r_ones;    // consecutive raw 1s, SYNC included
  logic [7:0] r_shift;   // remaining data bits, next one in bit 0

  logic [7:0] w_div_max;
  logic       w_bit_ce;
  logic       w_stuff;
  logic       w_byte_done;
  logic       w_sync_last;
  logic       w_emit;    // a raw bit goes onto the line at this bit_ce
  logic       w_raw;

  assign w_div_max   = r_ls ? DIV_MAX_LS : DIV_MAX_FS;
  assign w_bit_ce    = (r_state != ST_IDLE) && (r_div == w_div_max);
  assign w_stuff     = (r_ones == 3'd6);
  assign w_byte_done = (r_bitcnt == 4'd8);
  assign w_sync_last = (r_cnt == 3'd7);

  // At each bit_ce, pick the raw bit for the next bit period. A pending stuff bit
  // wins over everything, so it also goes out before EOP. At the end of SYNC or at
  // a byte boundary, the first bit of the new byte comes straight from the input.
  always_comb begin
    w_emit = 1'b0;
    w_raw  = 1'b0;
    if (w_bit_ce) begin
      case (r_state)
        ST_SYNC: begin
          if (!w_sync_last) begin
            w_emit = 1'b1;
            w_raw  = (r_cnt == 3'd6);
          end else if (utmi_txvalid_i) begin
            w_emit = 1'b1;
            w_raw  = utmi_data_i[0];
          end
        end
        ST_DATA: begin
          if (w_stuff) begin
            w_emit = 1'b1;
            w_raw  = 1'b0;
          end else if (!w_byte_done) begin
            w_emit = 1'b1;
            w_raw  = r_shift[0];
          end else if (utmi_txvalid_i) begin
            w_emit = 1'b1;
            w_raw  = utmi_data_i[0];
          end
        end
        default: begin
          w_emit = 1'b0;
          w_raw  = 1'b0;
        end
      endcase
    end
  end

  assign utmi_txready_o = w_bit_ce && utmi_txvalid_i &&
                          (((r_state == ST_SYNC) && w_sync_last) ||
                           ((r_state == ST_DATA) && !w_stuff && w_byte_done));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_div    <= 8'd0;
      r_ls     <= 1'b0;
      r_oe     <= 1'b0;
      r_level  <= 1'b1;
      r_se0    <= 1'b0;
      r_cnt    <= 3'd0;
      r_bitcnt <= 4'd0;
      r_ones   <= 3'd0;
      r_shift  <= 8'd0;
    end else begin
      if (r_state == ST_IDLE || w_bit_ce) r_div <= 8'd0;
      else                                r_div <= r_div + 8'd1;

      // NRZI: a raw 0 toggles the level, a raw 1 holds it and extends the run of ones.
      if (w_emit) begin
        r_level <= w_raw ? r_level : ~r_level;
        r_ones  <= w_raw ? r_ones + 3'd1 : 3'd0;
      end

      case (r_state)
        ST_IDLE: begin
          if (utmi_txvalid_i) begin
            r_state  <= ST_SYNC;
            r_ls     <= (utmi_xcvrselect_i == 2'b10);
            r_oe     <= 1'b1;
            r_se0    <= 1'b0;
            r_level  <= 1'b0;  // first SYNC bit is a raw 0: J -> K
            r_cnt    <= 3'd0;
            r_bitcnt <= 4'd0;
            r_ones   <= 3'd0;
          end
        end
        ST_SYNC: begin
          if (w_bit_ce) begin
            if (!w_sync_last) begin
              r_cnt <= r_cnt + 3'd1;
            end else if (utmi_txvalid_i) begin
              r_shift  <= {1'b0, utmi_data_i[7:1]};
              r_bitcnt <= 4'd1;
              r_state  <= ST_DATA;
            end else begin
              r_state <= ST_EOP_SE0;
              r_se0   <= 1'b1;
              r_cnt   <= 3'd0;
            end
          end
        end
        ST_DATA: begin
          if (w_bit_ce && !w_stuff) begin
            if (!w_byte_done) begin
              r_shift  <= {1'b0, r_shift[7:1]};
              r_bitcnt <= r_bitcnt + 4'd1;
            end else if (utmi_txvalid_i) begin
              r_shift  <= {1'b0, utmi_data_i[7:1]};
              r_bitcnt <= 4'd1;
            end else begin
              r_state <= ST_EOP_SE0;
              r_se0   <= 1'b1;
              r_cnt   <= 3'd0;
            end
          end
        end
        ST_EOP_SE0: begin
          if (w_bit_ce) begin
            if (r_cnt == 3'd1) begin
              r_state <= ST_EOP_J;
              r_se0   <= 1'b0;
              r_level <= 1'b1;
              r_cnt   <= 3'd0;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end
        end
        ST_EOP_J: begin
          if (w_bit_ce) begin
            r_state <= ST_IDLE;
            r_oe    <= 1'b0;
            r_level <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_oe    <= 1'b0;
        end
      endcase
    end
  end

  // J is (1,0) at full speed and (0,1) at low speed. SE0 forces both lines low.
  assign usb_dp_o = ~r_se0 & (r_level ^ r_ls);
  assign usb_dn_o = ~r_se0 & ~(r_level ^ r_ls);
  assign usb_oe_o = r_oe;
  assign busy_o   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_usb_phy_tx.sv
`timescale 1ns/1ps
module tb_usb_phy_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       txvalid;
  logic       txready;
  logic [1:0] xsel;
  logic       dp, dn, oe, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int first_oe = -1;
  int start_cyc = 0;

  logic [1:0] line_q[$];
  int         rdy_q[$];
  logic [7:0] rdy_dat_q[$];

  usb_phy_tx #(.CLK_DIV_FS(4), .CLK_DIV_LS(32)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .utmi_data_i       (data),
    .utmi_txvalid_i    (txvalid),
    .utmi_txready_o    (txready),
    .utmi_xcvrselect_i (xsel),
    .usb_dp_o          (dp),
    .usb_dn_o          (dn),
    .usb_oe_o          (oe),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record the line while driven, and every txready together with the byte it takes.
  always @(negedge clk) begin
    if (oe) begin
      line_q.push_back({dp, dn});
      if (first_oe < 0) first_oe = cyc;
    end
    if (txready) begin
      rdy_q.push_back(cyc);
      rdy_dat_q.push_back(data);
    end
  end

  // Turn the per-clock line record into one symbol per bit period.
  // A bit that does not hold steady for div clocks decodes as '?'.
  function automatic string decode(input int div, input logic ls);
    string s;
    logic [1:0] v;
    logic same;
    s = "";
    for (int b = 0; b * div < line_q.size(); b++) begin
      v = line_q[b * div];
      same = 1'b1;
      for (int j = 1; j < div; j++)
        if (b * div + j >= line_q.size() || line_q[b * div + j] !== v) same = 1'b0;
      if (!same)                             s = {s, "?"};
      else if (v == 2'b00)                   s = {s, "0"};
      else if (v == (ls ? 2'b01 : 2'b10))    s = {s, "J"};
      else if (v == (ls ? 2'b10 : 2'b01))    s = {s, "K"};
      else                                   s = {s, "X"};
    end
    return s;
  endfunction

  // Act as the SIE: send n bytes (b0,b1,b2), then switch xcvrselect to xs1 after the
  // first txready, drop txvalid after the last one, and wait for the block to go idle.
  task automatic drive_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input int n, input logic [1:0] xs0, input logic [1:0] xs1,
                              output logic ok);
    int got;
    logic idle;
    line_q.delete();
    rdy_q.delete();
    rdy_dat_q.delete();
    first_oe = -1;
    got = 0;
    idle = 1'b0;
    @(negedge clk);
    xsel = xs0;
    data = b0;
    txvalid = 1'b1;
    start_cyc = cyc;
    for (int k = 0; k < 4000 && got < n; k++) begin
      @(negedge clk);
      if (txready) begin
        got++;
        @(posedge clk);
        #1;
        xsel = xs1;
        data = (got == 1) ? b1 : b2;
        if (got == n) txvalid = 1'b0;
      end
    end
    txvalid = 1'b0;
    for (int k = 0; k < 4000 && !idle; k++) begin
      @(negedge clk);
      idle = !busy;
    end
    ok = idle && (got == n);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data = 8'h00;
    txvalid = 1'b0;
    xsel = 2'b00;
    repeat (3) @(negedge clk);
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", oe); end
    checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL reset_dn got %b want 0", dn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (txready !== 1'b0) begin errors++; $display("FAIL reset_txready got %b want 0", txready); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset oe=%b busy=%b want 0 0", oe, busy); end
  endtask

  task automatic test_fs_ack();
    logic ok;
    string got;
    drive_packet(8'hD2, 8'h00, 8'h00, 1, 2'b00, 2'b00, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ack_timeout got %b want 1", ok); end
    checks++; if (first_oe - start_cyc !== 1) begin errors++; $display("FAIL ack_start_latency got %0d want 1", first_oe - start_cyc); end
    checks++; if (rdy_q.size() !== 1) begin errors++; $display("FAIL ack_txready_count got %0d want 1", rdy_q.size()); end
    else begin
      checks++; if (rdy_q[0] - start_cyc !== 32) begin errors++; $display("FAIL ack_first_txready got %0d want 32", rdy_q[0] - start_cyc); end
    end
    got = decode(4, 1'b0);
    checks++; if (got != "KJKJKJKKJJKJJKKK00J") begin errors++; $display("FAIL ack_line got %s want KJKJKJKKJJKJJKKK00J", got); end
    checks++; if (oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ack_end oe=%b busy=%b want 0 0", oe, busy); end
  endtask

  task automatic test_bit_stuff();
    logic ok;
    string got;
    string exp;
    exp = {"KJKJKJKK", "KKKKKJJJJ", "KJKJKJKJ", "KJKJKJKJ", "00J"};
    drive_packet(8'hFF, 8'h00, 8'h00, 3, 2'b00, 2'b00, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stuff_timeout got %b want 1", ok); end
    got = decode(4, 1'b0);
    checks++; if (got != exp) begin errors++; $display("FAIL stuff_line got %s want %s", got, exp); end
    checks++; if (rdy_q.size() !== 3) begin errors++; $display("FAIL stuff_txready_count got %0d want 3", rdy_q.size()); end
    else begin
      checks++; if (rdy_q[1] - rdy_q[0] !== 36) begin errors++; $display("FAIL stuff_interval_ff got %0d want 36", rdy_q[1] - rdy_q[0]); end
      checks++; if (rdy_q[2] - rdy_q[1] !== 32) begin errors++; $display("FAIL stuff_interval_00 got %0d want 32", rdy_q[2] - rdy_q[1]); end
    end
  endtask

  task automatic test_low_speed();
    logic ok;
    string got;
    drive_packet(8'hD2, 8'h00, 8'h00, 1, 2'b10, 2'b00, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ls_timeout got %b want 1", ok); end
    got = decode(32, 1'b1);
    checks++; if (got != "KJKJKJKKJJKJJKKK00J") begin errors++; $display("FAIL ls_line got %s want KJKJKJKKJJKJJKKK00J", got); end
    checks++; if (rdy_q.size() !== 1) begin errors++; $display("FAIL ls_txready_count got %0d want 1", rdy_q.size()); end
    else begin
      checks++; if (rdy_q[0] - start_cyc !== 256) begin errors++; $display("FAIL ls_first_txready got %0d want 256", rdy_q[0] - start_cyc); end
    end
  endtask

  task automatic test_three_bytes();
    logic ok;
    string got;
    string exp;
    exp = {"KJKJKJKK", "KJKJKKKK", "KJJKKJKJ", "KJKJJKJK", "00J"};
    drive_packet(8'hE1, 8'h15, 8'h10, 3, 2'b00, 2'b00, ok);
    checks++; if (!ok) begin errors++; $display("FAIL three_timeout got %b want 1", ok); end
    got = decode(4, 1'b0);
    checks++; if (got != exp) begin errors++; $display("FAIL three_line got %s want %s", got, exp); end
    checks++; if (rdy_dat_q.size() !== 3) begin errors++; $display("FAIL three_txready_count got %0d want 3", rdy_dat_q.size()); end
    else begin
      checks++; if (rdy_dat_q[0] !== 8'hE1) begin errors++; $display("FAIL three_byte0 got %h want e1", rdy_dat_q[0]); end
      checks++; if (rdy_dat_q[1] !== 8'h15) begin errors++; $display("FAIL three_byte1 got %h want 15", rdy_dat_q[1]); end
      checks++; if (rdy_dat_q[2] !== 8'h10) begin errors++; $display("FAIL three_byte2 got %h want 10", rdy_dat_q[2]); end
    end
  endtask

  task automatic test_xcvr_change();
    logic ok;
    string got;
    string exp;
    exp = {"KJKJKJKK", "JJKJJKKK", "JJKJJKKK", "00J"};
    drive_packet(8'hD2, 8'hD2, 8'h00, 2, 2'b00, 2'b10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL xsel_timeout got %b want 1", ok); end
    got = decode(4, 1'b0);
    checks++; if (got != exp) begin errors++; $display("FAIL xsel_line got %s want %s", got, exp); end
    checks++; if (rdy_q.size() !== 2) begin errors++; $display("FAIL xsel_txready_count got %0d want 2", rdy_q.size()); end
    else begin
      checks++; if (rdy_q[1] - rdy_q[0] !== 32) begin errors++; $display("FAIL xsel_interval got %0d want 32", rdy_q[1] - rdy_q[0]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    logic ok;
    logic seen;
    string got;
    seen = 1'b0;
    @(negedge clk);
    xsel = 2'b00;
    data = 8'hAA;
    txvalid = 1'b1;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      seen = txready;
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_mid_no_txready got %b want 1", seen); end
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1 || oe !== 1'b1) begin errors++; $display("FAIL rst_mid_active busy=%b oe=%b want 1 1", busy, oe); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe got %b want 0", oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    txvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive_packet(8'hD2, 8'h00, 8'h00, 1, 2'b00, 2'b00, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_after_timeout got %b want 1", ok); end
    got = decode(4, 1'b0);
    checks++; if (got != "KJKJKJKKJJKJJKKK00J") begin errors++; $display("FAIL rst_after_line got %s want KJKJKJKKJJKJJKKK00J", got); end
    checks++; if (rdy_q.size() !== 1) begin errors++; $display("FAIL rst_after_txready_count got %0d want 1", rdy_q.size()); end
    else begin
      checks++; if (rdy_q[0] - start_cyc !== 32) begin errors++; $display("FAIL rst_after_first_txready got %0d want 32", rdy_q[0] - start_cyc); end
    end
  endtask

  initial begin
    test_reset();
    test_fs_ack();
    test_bit_stuff();
    test_low_speed();
    test_three_bytes();
    test_xcvr_change();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
